stream_arb2: RTL
================

STREAM_ARB2 -- requirements
Module: stream_arb2

Interface
REQ-001 SHALL have parameter DW, default 8, data width of every data port.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum consecutive beats accepted from one source before re-arbitration; legal range 1..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports a_data input DW, a_valid input 1, a_ready output 1: source A stream.
REQ-006 SHALL have ports b_data input DW, b_valid input 1, b_ready output 1: source B stream.
REQ-007 SHALL have ports y_data output DW, y_valid output 1, y_ready input 1: merged output stream.
REQ-008 SHALL have port sel  output  1  current grant (0 = A, 1 = B), for a downstream 2:1 select.

Function
REQ-009 SHALL implement states IDLE, GNT_A, GNT_B, plus a last_gnt bit and a burst counter cnt of width clog2(MAX_BURST), minimum 1 bit.
REQ-010 SHALL, in IDLE, go to GNT_A if a_valid and (not b_valid or last_gnt = B); else go to GNT_B if b_valid; else stay in IDLE.
REQ-011 SHALL accept no beat in IDLE; a_ready = b_ready = 0 there.
REQ-012 SHALL drive a_ready = (state = GNT_A) and (not y_valid or y_ready); b_ready likewise for GNT_B.
REQ-013 SHALL count a beat as accepted when valid and ready are both high on the granted source; each accept increments cnt.
REQ-014 SHALL end a grant when the granted source's valid is low, or on an accept with cnt = MAX_BURST-1.
REQ-015 SHALL, at grant end, set last_gnt to the ending source and clear cnt.
REQ-016 SHALL, at grant end, go directly to the other source's grant if that source's valid is high.
REQ-017 SHALL otherwise re-grant the same source if its valid is high; otherwise go to IDLE.
REQ-018 SHALL register the output: on an accept, y_data <= granted data and y_valid <= 1 on the next edge.
REQ-019 SHALL clear y_valid when y_valid and y_ready are high with no simultaneous accept.
REQ-020 SHALL hold y_data and y_valid stable while y_valid = 1 and y_ready = 0.
REQ-021 SHALL sustain one beat per cycle when y_ready stays high; simultaneous drain and accept replaces the output beat.
REQ-022 SHALL give a latency of two cycles from a_valid rising in IDLE to y_valid high: one cycle for grant, one for the register.
REQ-023 SHALL drive sel = 1 only in GNT_B; sel SHALL be registered, not combinational.
REQ-024 SHALL never assert a_ready and b_ready in the same cycle, and SHALL never drop or duplicate a beat.
REQ-025 SHALL treat a source dropping valid mid-burst as grant end per REQ-014, with no data loss.

Reset
REQ-026 SHALL, while rst = 1, force: state IDLE, cnt 0, last_gnt B (A wins first), y_valid 0, y_data 0, sel 0, a_ready 0, b_ready 0.
REQ-027 SHALL make reset asserted mid-burst discard any held output beat; the first beat after release follows REQ-010.

Structure
REQ-028 SHALL place the state encoding (IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2) and the count-width function in shared package stream_arb2_pkg.
REQ-029 SHALL implement the grant FSM, last_gnt and cnt in sub-module arb_rr2 (ports: clk, rst, req_a, req_b, acc, gnt_a, gnt_b); the output register and data select SHALL stay in stream_arb2.

Verification
REQ-030 SHALL cover A only: a_data 0x11..0x16 continuous, MAX_BURST=4, y_ready=1 -> y order 11,12,13,14,15,16; one re-grant bubble-free; b_ready never 1.
REQ-031 SHALL cover both sources continuous, A=0xA0.., B=0xB0.., MAX_BURST=4 -> y order A0-A3, B0-B3, A4-A7; sel toggles every 4 beats.
REQ-032 SHALL cover backpressure: y_ready=0 for 5 cycles after the first beat 0x11 -> y_data holds 0x11, y_valid stays 1, a_ready=0; resume -> no loss.
REQ-033 SHALL cover A dropping valid after 2 beats while B is valid -> next cycle GNT_B, sel=1, cnt restarts at 0.
REQ-034 SHALL cover simultaneous first request from reset, a_valid=b_valid=1 -> A granted first (last_gnt reset to B).
REQ-035 SHALL cover rst pulse mid-burst with y_valid=1 -> y_valid=0 and sel=0 immediately; after release, arbitration restarts from IDLE.

Source files
------------

// File: rtl/stream_arb2_pkg.sv
// Shared definitions for the two-source round-robin stream arbiter:
// grant state encoding and the burst-counter width helper.
package stream_arb2_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StGntA = 2'd1;
  localparam state_t StGntB = 2'd2;

  // Width of a counter that must reach n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Round-robin grant FSM for two requesters with a per-grant burst limit.
// Holds the current grant, the last source served and the beat counter.
module arb_rr2
  import stream_arb2_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic acc,
  output logic gnt_a,
  output logic gnt_b
);

  localparam int unsigned CW = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CntLast = CW'(MAX_BURST - 1);

  state_t        state_q, state_d;
  logic          last_gnt_q, last_gnt_d;  // 1 = B was served last
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cur_is_b, cur_req, oth_req, grant_end;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    cur_is_b   = (state_q == StGntB);
    cur_req    = cur_is_b ? req_b : req_a;
    oth_req    = cur_is_b ? req_a : req_b;
    grant_end  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_a && (!req_b || last_gnt_q)) begin
          state_d = StGntA;
        end else if (req_b) begin
          state_d = StGntB;
        end
      end
      StGntA, StGntB: begin
        grant_end = !cur_req || (acc && (cnt_q == CntLast));
        if (grant_end) begin
          last_gnt_d = cur_is_b;
          cnt_d      = '0;
          // Hand over to the other side first; re-grant only if it is idle.
          if (oth_req) begin
            state_d = cur_is_b ? StGntA : StGntB;
          end else if (cur_req) begin
            state_d = state_q;
          end else begin
            state_d = StIdle;
          end
        end else if (acc) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign gnt_a = (state_q == StGntA);
  assign gnt_b = (state_q == StGntB);

endmodule

// File: rtl/stream_arb2.sv
// Two-input valid/ready stream merger with round-robin burst arbitration
// and a registered output stage.
module stream_arb2
  import stream_arb2_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a_data,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [DW-1:0] b_data,
  input  logic          b_valid,
  output logic          b_ready,
  output logic [DW-1:0] y_data,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          sel
);

  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
    $error("stream_arb2: MAX_BURST must be in 1..16");
  end

  logic          gnt_a, gnt_b;
  logic          out_free, acc;
  logic [DW-1:0] y_data_q, y_data_d;
  logic          y_valid_q, y_valid_d;

  arb_rr2 #(
    .MAX_BURST(MAX_BURST)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req_a(a_valid),
    .req_b(b_valid),
    .acc  (acc),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b)
  );

  // The output slot can take a new beat when empty or draining this cycle.
  assign out_free = !y_valid_q || y_ready;
  assign a_ready  = gnt_a && out_free;
  assign b_ready  = gnt_b && out_free;
  assign acc      = (a_valid && a_ready) || (b_valid && b_ready);

  always_comb begin
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    if (acc) begin
      y_valid_d = 1'b1;
      y_data_d  = gnt_b ? b_data : a_data;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign sel     = gnt_b;

  a_mutex: assert property (@(posedge clk) disable iff (rst) !(a_ready && b_ready));

endmodule
